// File: rtl/nem_ohmux_sel_ctrl.sv
// Round-robin select sequencer for a 4-input one-hot NEM-relay mux.
// Drives the relay selects with break-before-make timing.
module nem_ohmux_sel_ctrl #(
  parameter int N_IN    = 4,
  parameter int PI_CYC  = 5,
  parameter int REL_CYC = 3,
  parameter int CNT_W   = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_IN-1:0] REQ,
  output logic [N_IN-1:0] S,
  output logic [N_IN-1:0] GNT,
  output logic [1:0]      OWNER,
  output logic            BUSY
);

  typedef enum logic [1:0] {IDLE, MAKE, HOLD, BREAK} state_t;

  localparam logic [CNT_W-1:0] PI_LOAD  = CNT_W'(PI_CYC - 1);
  localparam logic [CNT_W-1:0] REL_LOAD = CNT_W'(REL_CYC - 1);

  state_t           state_r;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       owner_nxt;
  logic [1:0]       pick_s;
  logic [N_IN-1:0]  s_nxt;
  logic [N_IN-1:0]  gnt_nxt;
  logic             busy_nxt;

  function automatic logic [N_IN-1:0] onehot(input logic [1:0] idx);
    return N_IN'(1) << idx;
  endfunction

  // First requester strictly after the last owner, wrapping around.
  function automatic logic [1:0] rr_pick(input logic [N_IN-1:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    idx   = last;
    pick  = last;
    found = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      idx   = idx + 2'd1;
      pick  = (!found && req[idx]) ? idx : pick;
      found = found | req[idx];
    end
    return pick;
  endfunction

  assign pick_s = rr_pick(REQ, OWNER);

  // Next-state, counter and next registered output values.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    owner_nxt = OWNER;
    s_nxt     = S;
    gnt_nxt   = {N_IN{1'b0}};
    busy_nxt  = 1'b1;
    case (state_r)
      IDLE: begin
        if (REQ != {N_IN{1'b0}}) begin
          owner_nxt = pick_s;
          s_nxt     = onehot(pick_s);
          cnt_nxt   = PI_LOAD;
          state_nxt = MAKE;
        end else begin
          s_nxt    = {N_IN{1'b0}};
          busy_nxt = 1'b0;
        end
      end
      MAKE: begin
        s_nxt = onehot(OWNER);
        if (cnt_r == {CNT_W{1'b0}}) begin
          gnt_nxt   = onehot(OWNER);
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt_r - CNT_W'(1);
        end
      end
      HOLD: begin
        // Pull-in is already complete, so a drop here always goes through a full release.
        if (!REQ[OWNER]) begin
          s_nxt     = {N_IN{1'b0}};
          cnt_nxt   = REL_LOAD;
          state_nxt = BREAK;
        end else begin
          s_nxt   = onehot(OWNER);
          gnt_nxt = onehot(OWNER);
        end
      end
      BREAK: begin
        s_nxt = {N_IN{1'b0}};
        if (cnt_r == {CNT_W{1'b0}}) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        s_nxt     = {N_IN{1'b0}};
        busy_nxt  = 1'b0;
        cnt_nxt   = {CNT_W{1'b0}};
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      OWNER   <= 2'd3;
      S       <= {N_IN{1'b0}};
      GNT     <= {N_IN{1'b0}};
      BUSY    <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      OWNER   <= owner_nxt;
      S       <= s_nxt;
      GNT     <= gnt_nxt;
      BUSY    <= busy_nxt;
    end
  end

endmodule
